// File: rtl/nf_table_store.sv
`default_nettype none
// ============================================================================
// Module      : nf_table_store
// Description : Row-addressed table of TBL_NUM_ROWS x (W*TBL_NUM_COLS) flops.
//               Register side: request/acknowledge read and write port,
//               serialised by a small FSM (write wins when both requests
//               are raised together). Datapath side: one lookup per cycle,
//               result one cycle later, never stalled.
// Ports       : Bus2IP_Clk, Bus2IP_Resetn (async, active-low)
//               tbl_rd_req/ack/addr/data  register-side read
//               tbl_wr_req/ack/addr/data  register-side write
//               lkp_valid/addr -> lkp_data_valid/lkp_data  datapath lookup
// Revision    : 1.0  initial release
// ============================================================================
module nf_table_store #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TBL_NUM_COLS       = 4,
    parameter int TBL_NUM_ROWS       = 4,
    localparam int AW = (TBL_NUM_ROWS > 1) ? $clog2(TBL_NUM_ROWS) : 1,
    localparam int RW = C_S_AXI_DATA_WIDTH * TBL_NUM_COLS
) (
    input  logic          Bus2IP_Clk,
    input  logic          Bus2IP_Resetn,
    input  logic          tbl_rd_req,
    output logic          tbl_rd_ack,
    input  logic [AW-1:0] tbl_rd_addr,
    output logic [RW-1:0] tbl_rd_data,
    input  logic          tbl_wr_req,
    output logic          tbl_wr_ack,
    input  logic [AW-1:0] tbl_wr_addr,
    input  logic [RW-1:0] tbl_wr_data,
    input  logic          lkp_valid,
    input  logic [AW-1:0] lkp_addr,
    output logic          lkp_data_valid,
    output logic [RW-1:0] lkp_data
);

    // Row count at address width + 1 so out-of-range addresses can be
    // detected when TBL_NUM_ROWS is not a power of two.
    localparam logic [AW:0] ROWS_C = (AW+1)'(TBL_NUM_ROWS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DONE = 2'd1,
        WR_DONE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          served_wr_q, served_wr_d;   // request HOLD waits on
    logic [RW-1:0] rows_q [TBL_NUM_ROWS];
    logic [RW-1:0] rd_data_q;
    logic          lkp_valid_q;
    logic [RW-1:0] lkp_data_q;

    logic          wr_en;
    logic          rd_en;
    logic          wr_in_range;
    logic          rd_in_range;
    logic          lkp_in_range;

    assign wr_in_range  = ({1'b0, tbl_wr_addr} < ROWS_C);
    assign rd_in_range  = ({1'b0, tbl_rd_addr} < ROWS_C);
    assign lkp_in_range = ({1'b0, lkp_addr}    < ROWS_C);

    // ------------------------------------------------------------------
    // Register-port FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q     <= IDLE;
            served_wr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            served_wr_q <= served_wr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        served_wr_d = served_wr_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (tbl_wr_req) begin
                    wr_en       = 1'b1;
                    served_wr_d = 1'b1;
                    state_d     = WR_DONE;
                end else if (tbl_rd_req) begin
                    rd_en       = 1'b1;
                    served_wr_d = 1'b0;
                    state_d     = RD_DONE;
                end
            end
            RD_DONE, WR_DONE: state_d = HOLD;
            HOLD: begin
                // Only the request that was served must drop; a pending
                // read raised alongside a write is picked up in IDLE.
                if (served_wr_q ? !tbl_wr_req : !tbl_rd_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tbl_wr_ack = (state_q == WR_DONE);
    assign tbl_rd_ack = (state_q == RD_DONE);

    // ------------------------------------------------------------------
    // Table storage; out-of-range writes are acknowledged and dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            for (int i = 0; i < TBL_NUM_ROWS; i++) begin
                rows_q[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            rows_q[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Register read capture; holds until the next capture.
    // ------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= rd_in_range ? rows_q[tbl_rd_addr] : '0;
        end
    end

    assign tbl_rd_data = rd_data_q;

    // ------------------------------------------------------------------
    // Lookup path, independent of the FSM. Reads the pre-edge table, so a
    // write at the same edge is seen only by later lookups.
    // ------------------------------------------------------------------
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            lkp_valid_q <= 1'b0;
            lkp_data_q  <= '0;
        end else begin
            lkp_valid_q <= lkp_valid;
            if (lkp_valid) begin
                lkp_data_q <= lkp_in_range ? rows_q[lkp_addr] : '0;
            end
        end
    end

    assign lkp_data_valid = lkp_valid_q;
    assign lkp_data       = lkp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_nf_table_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_nf_table_store
// Description : Self-checking bench. Two instances share every input: one
//               with 4 rows, one with 3 rows (address 3 out of range). A
//               transaction-level table model predicts acks, read data and
//               lookup results every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nf_table_store;

    localparam int W  = 32;
    localparam int RW = W * 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rd_req, wr_req, lkp_valid;
    logic [1:0]    rd_addr, wr_addr, lkp_addr;
    logic [RW-1:0] wr_data;

    logic          rd_ack4, wr_ack4, lv4, rd_ack3, wr_ack3, lv3;
    logic [RW-1:0] rd_data4, ld4, rd_data3, ld3;

    always #5 clk = ~clk;

    nf_table_store #(.C_S_AXI_DATA_WIDTH(W), .TBL_NUM_COLS(4), .TBL_NUM_ROWS(4)) dut4 (
        .Bus2IP_Clk(clk), .Bus2IP_Resetn(resetn),
        .tbl_rd_req(rd_req), .tbl_rd_ack(rd_ack4), .tbl_rd_addr(rd_addr), .tbl_rd_data(rd_data4),
        .tbl_wr_req(wr_req), .tbl_wr_ack(wr_ack4), .tbl_wr_addr(wr_addr), .tbl_wr_data(wr_data),
        .lkp_valid(lkp_valid), .lkp_addr(lkp_addr), .lkp_data_valid(lv4), .lkp_data(ld4)
    );

    nf_table_store #(.C_S_AXI_DATA_WIDTH(W), .TBL_NUM_COLS(4), .TBL_NUM_ROWS(3)) dut3 (
        .Bus2IP_Clk(clk), .Bus2IP_Resetn(resetn),
        .tbl_rd_req(rd_req), .tbl_rd_ack(rd_ack3), .tbl_rd_addr(rd_addr), .tbl_rd_data(rd_data3),
        .tbl_wr_req(wr_req), .tbl_wr_ack(wr_ack3), .tbl_wr_addr(wr_addr), .tbl_wr_data(wr_data),
        .lkp_valid(lkp_valid), .lkp_addr(lkp_addr), .lkp_data_valid(lv3), .lkp_data(ld3)
    );

    // Reference model: table contents per instance (m3[3] is never written).
    logic [RW-1:0] m4 [4];
    logic [RW-1:0] m3 [4];

    // Expected outputs, refreshed by the transaction tasks / tick.
    logic          exp_wr_ack, exp_rd_ack, exp_lv;
    logic [RW-1:0] exp_rd4, exp_rd3, exp_ld4, exp_ld3;
    logic          apply_wr, rd_capture, rand_lkp;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            m4[i] = '0;
            m3[i] = '0;
        end
        exp_rd4 = '0; exp_rd3 = '0; exp_ld4 = '0; exp_ld3 = '0;
        exp_lv  = 1'b0; exp_wr_ack = 1'b0; exp_rd_ack = 1'b0;
    endtask

    task automatic check_all();
        chk("wr_ack4", {127'd0, wr_ack4}, {127'd0, exp_wr_ack});
        chk("wr_ack3", {127'd0, wr_ack3}, {127'd0, exp_wr_ack});
        chk("rd_ack4", {127'd0, rd_ack4}, {127'd0, exp_rd_ack});
        chk("rd_ack3", {127'd0, rd_ack3}, {127'd0, exp_rd_ack});
        chk("rd_data4", rd_data4, exp_rd4);
        chk("rd_data3", rd_data3, exp_rd3);
        chk("lkp_valid4", {127'd0, lv4}, {127'd0, exp_lv});
        chk("lkp_valid3", {127'd0, lv3}, {127'd0, exp_lv});
        chk("lkp_data4", ld4, exp_ld4);
        chk("lkp_data3", ld3, exp_ld3);
    endtask

    // One clock: predict from the pre-edge table, advance, apply any write
    // taking place at this edge, then compare every output.
    task automatic tick();
        exp_lv = lkp_valid;
        if (lkp_valid) begin
            exp_ld4 = m4[lkp_addr];
            exp_ld3 = m3[lkp_addr];
        end
        if (rd_capture) begin
            exp_rd4 = m4[rd_addr];
            exp_rd3 = m3[rd_addr];
            rd_capture = 1'b0;
        end
        @(posedge clk);
        #1;
        if (apply_wr) begin
            m4[wr_addr] = wr_data;
            if (wr_addr < 2'd3) m3[wr_addr] = wr_data;
            apply_wr = 1'b0;
        end
        check_all();
        if (rand_lkp) begin
            lkp_valid = 1'($urandom_range(0, 1));
            lkp_addr  = 2'($urandom_range(0, 3));
        end
    endtask

    // Write transaction from IDLE; request held 'hold' extra cycles in HOLD.
    task automatic reg_write(input logic [1:0] a, input logic [RW-1:0] d, input int hold);
        wr_addr = a; wr_data = d; wr_req = 1'b1;
        apply_wr = 1'b1; exp_wr_ack = 1'b1;
        tick();
        exp_wr_ack = 1'b0;
        repeat (hold) tick();
        wr_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic reg_read(input logic [1:0] a, input int hold);
        rd_addr = a; rd_req = 1'b1;
        rd_capture = 1'b1; exp_rd_ack = 1'b1;
        tick();
        exp_rd_ack = 1'b0;
        repeat (hold) tick();
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0; lkp_valid = 1'b0;
        rd_addr = '0; wr_addr = '0; lkp_addr = '0; wr_data = '0;
        apply_wr = 1'b0; rd_capture = 1'b0; rand_lkp = 1'b0;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        resetn = 1'b1;
        tick();

        // Write row 2, request held two extra cycles, then read it back
        reg_write(2'd2, {32'h44, 32'h33, 32'h22, 32'h11}, 2);
        reg_read(2'd2, 1);
        chk("row2_literal", rd_data4, 128'h00000044_00000033_00000022_00000011);

        // Simultaneous write and read of row 1: write first, read after HOLD
        wr_addr = 2'd1; wr_data = {4{32'hAAAA_5555}}; wr_req = 1'b1; rd_addr = 2'd1; rd_req = 1'b1;
        apply_wr = 1'b1; exp_wr_ack = 1'b1;
        tick();
        exp_wr_ack = 1'b0;
        wr_req = 1'b0;
        tick();
        tick();
        rd_capture = 1'b1; exp_rd_ack = 1'b1;
        tick();
        exp_rd_ack = 1'b0;
        rd_req = 1'b0;
        tick();
        tick();
        chk("simul_rd_row1", rd_data4, {4{32'hAAAA_5555}});

        // Lookup on the same edge as a write to that row
        reg_write(2'd1, '0, 0);
        lkp_valid = 1'b1; lkp_addr = 2'd1;
        reg_write(2'd1, 128'h5, 0);
        chk("lkp_after_write", ld4, 128'h5);
        lkp_valid = 1'b0;
        tick();

        // Back-to-back lookups of rows 0..3 while a register read is held
        reg_write(2'd0, {4{32'h0000_00A0}}, 0);
        reg_write(2'd3, {4{32'h0000_00D3}}, 0);
        rd_addr = 2'd0; rd_req = 1'b1; rd_capture = 1'b1; exp_rd_ack = 1'b1;
        lkp_valid = 1'b1; lkp_addr = 2'd0;
        tick();
        exp_rd_ack = 1'b0;
        for (int i = 1; i < 4; i++) begin
            lkp_addr = 2'(i);
            tick();
        end
        lkp_valid = 1'b0; rd_req = 1'b0;
        tick();
        tick();

        // Out-of-range address on the 3-row instance
        reg_write(2'd3, {RW{1'b1}}, 1);
        reg_read(2'd3, 0);
        chk("oor_read3", rd_data3, '0);
        for (int i = 0; i < 3; i++) begin
            rd_addr = 2'(i);
            reg_read(2'(i), 0);
        end

        // Randomised traffic with random lookups every cycle
        rand_lkp = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 2))
                0: reg_write(2'($urandom_range(0, 3)),
                             {$urandom, $urandom, $urandom, $urandom},
                             int'($urandom_range(0, 2)));
                1: reg_read(2'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
                default: tick();
            endcase
        end
        rand_lkp = 1'b0;
        lkp_valid = 1'b0;
        tick();

        // Reset asserted while in RD_DONE, read request held across it
        rd_addr = 2'd2; rd_req = 1'b1; rd_capture = 1'b1; exp_rd_ack = 1'b1;
        tick();
        exp_rd_ack = 1'b0;
        resetn = 1'b0;
        #1;
        clear_model();
        check_all();
        tick();
        tick();
        resetn = 1'b1;
        rd_capture = 1'b1; exp_rd_ack = 1'b1;
        tick();
        exp_rd_ack = 1'b0;
        rd_req = 1'b0;
        tick();
        tick();

        // Lookups after reset see a cleared table
        lkp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lkp_addr = 2'(i);
            tick();
        end
        lkp_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nf_table_store.md
NF_TABLE_STORE -- requirements
Module: nf_table_store

Interface
REQ-001 Parameter C_S_AXI_DATA_WIDTH, default 32: width of one table cell (column).
REQ-002 Parameter TBL_NUM_COLS, default 4: cells per row.
REQ-003 Parameter TBL_NUM_ROWS, default 4: rows in table; AW = log2(TBL_NUM_ROWS) (ceiling, minimum 1).
REQ-004 Bus2IP_Clk  in  1  single clock for all logic.
REQ-005 Bus2IP_Resetn  in  1  reset, asynchronous, active-low.
REQ-006 tbl_rd_req  in  1  register-side read request, held high until ack observed.
REQ-007 tbl_rd_ack  out  1  one-cycle read acknowledge pulse.
REQ-008 tbl_rd_addr  in  AW  row to read.
REQ-009 tbl_rd_data  out  C_S_AXI_DATA_WIDTH*TBL_NUM_COLS  row read; column i at bits [W*(i+1)-1 : W*i].
REQ-010 tbl_wr_req  in  1  register-side write request, held high until ack observed.
REQ-011 tbl_wr_ack  out  1  one-cycle write acknowledge pulse.
REQ-012 tbl_wr_addr  in  AW  row to write.
REQ-013 tbl_wr_data  in  C_S_AXI_DATA_WIDTH*TBL_NUM_COLS  row value to write, same packing as tbl_rd_data.
REQ-014 lkp_valid  in  1  datapath lookup request, one per cycle, no backpressure.
REQ-015 lkp_addr  in  AW  row for lookup.
REQ-016 lkp_data_valid  out  1  lookup result valid.
REQ-017 lkp_data  out  C_S_AXI_DATA_WIDTH*TBL_NUM_COLS  lookup result row.

Function
REQ-018 Storage SHALL be TBL_NUM_ROWS x (W*TBL_NUM_COLS) flops, written only via the register-side write port.
REQ-019 Register-port FSM SHALL have states IDLE, RD_DONE, WR_DONE, HOLD.
REQ-020 IDLE: tbl_wr_req=1 -> write row tbl_wr_addr with tbl_wr_data at this edge, go WR_DONE; else tbl_rd_req=1 -> capture row tbl_rd_addr into tbl_rd_data, go RD_DONE; else stay.
REQ-021 Simultaneous tbl_wr_req and tbl_rd_req in IDLE: write served first; read served after HOLD exits and the read request is still pending.
REQ-022 WR_DONE / RD_DONE: assert tbl_wr_ack / tbl_rd_ack for exactly this one cycle, then go HOLD.
REQ-023 HOLD: stay until the request just served is low; then IDLE; no second ack for a request still held high.
REQ-024 Latency: request sampled at edge N -> ack high during cycle N+1; minimum request-to-request spacing 3 cycles.
REQ-025 tbl_rd_data SHALL hold its captured value until the next read capture.
REQ-026 Lookup: lkp_valid sampled at edge N -> lkp_data_valid=1 and lkp_data = row lkp_addr during cycle N+1; lkp_data_valid=0 when lkp_valid was 0; lkp_data holds last value.
REQ-027 Lookup and register write to the same row at the same edge: lookup returns the pre-write value; the next lookup returns the new value.
REQ-028 Register read and register write, same row, never overlap (FSM serialises); register read after write ack returns the written value.
REQ-029 Address >= TBL_NUM_ROWS (non-power-of-2 rows): write acked and discarded; read and lookup return all zeros; acks and valids behave normally.
REQ-030 Lookup path SHALL be independent of the FSM; a lookup is never stalled or dropped.

Reset
REQ-031 Bus2IP_Resetn=0 asynchronously: all rows 0, FSM IDLE, tbl_rd_ack=0, tbl_wr_ack=0, tbl_rd_data=0, lkp_data_valid=0, lkp_data=0.
REQ-032 Reset mid-transaction aborts it with no ack after release; a write sampled at the same edge reset asserts is lost.
REQ-033 After release, requests still held high are served as new requests from IDLE.

Verification
REQ-034 Write row 2 = {0x44,0x33,0x22,0x11}, hold req until ack -> one-cycle tbl_wr_ack at N+1, no second ack while req held; read row 2 -> tbl_rd_data=0x00000044_00000033_00000022_00000011.
REQ-035 tbl_wr_req and tbl_rd_req both high in IDLE (wr row 1=0xA..., rd row 1) -> wr_ack first, then rd_ack after HOLD exit, read returns new row 1 value.
REQ-036 lkp_valid=1, lkp_addr=1 on the edge row 1 is written 0x5 (old 0x0) -> lkp_data=0x0 next cycle; repeat lookup -> 0x5.
REQ-037 Back-to-back lookups of rows 0,1,2,3 over 4 cycles during a pending register read -> 4 consecutive lkp_data_valid pulses, correct rows, register read still acked once.
REQ-038 TBL_NUM_ROWS=3, write addr 3 = 0xFF.. -> acked, rows 0-2 unchanged; read/lookup addr 3 -> 0.
REQ-039 Assert Bus2IP_Resetn=0 in RD_DONE -> ack drops immediately, all rows and outputs 0; release with tbl_rd_req still high -> fresh ack 1 cycle later, data 0.
